// File: rtl/bp_two_level_bht_updater.sv
// Training side of the two-level branch predictor: queues resolved branches and
// runs one LHT/PHT read-modify-write per entry, four cycles per update.
module bp_two_level_bht_updater #(
    parameter int PC_IDX_W   = 4,
    parameter int HIST_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                resolve_v_i,
    output logic                resolve_ready_o,
    input  logic [31:0]         resolve_pc_i,
    input  logic                resolve_taken_i,
    output logic                lht_r_v_o,
    output logic [PC_IDX_W-1:0] lht_r_addr_o,
    input  logic [HIST_W-1:0]   lht_r_data_i,
    output logic                lht_w_v_o,
    output logic [PC_IDX_W-1:0] lht_w_addr_o,
    output logic [HIST_W-1:0]   lht_w_data_o,
    output logic                pht_r_v_o,
    output logic [HIST_W-1:0]   pht_r_addr_o,
    input  logic [1:0]          pht_r_data_i,
    output logic                pht_w_v_o,
    output logic [HIST_W-1:0]   pht_w_addr_o,
    output logic [1:0]          pht_w_data_o,
    output logic                busy_o,
    output logic [15:0]         update_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RD_LHT, S_RD_PHT, S_WRITE} state_e;
    typedef logic [PC_IDX_W:0] entry_t;

    entry_t              fifo_q [FIFO_DEPTH];
    entry_t              fifo_d [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_e              state_q, state_d;
    logic [PC_IDX_W-1:0] idx_q, idx_d;
    logic                taken_q, taken_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic                lht_w_v_q, lht_w_v_d, pht_w_v_q, pht_w_v_d;
    logic [PC_IDX_W-1:0] lht_w_addr_q, lht_w_addr_d;
    logic [HIST_W-1:0]   lht_w_data_q, lht_w_data_d, pht_w_addr_q, pht_w_addr_d;
    logic [1:0]          pht_w_data_q, pht_w_data_d;
    logic [15:0]         count_q, count_d;

    logic   full, empty, push, pop;
    entry_t head;
    logic   unused_pc;

    assign unused_pc = ^{resolve_pc_i[31:PC_IDX_W+2], resolve_pc_i[1:0]};

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        // Wrap bits differ and indices match: all slots occupied.
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        push  = resolve_v_i && !full;
        pop   = (state_q == S_IDLE) && !empty;
        head  = fifo_q[rd_ptr_q[PTR_W-1:0]];

        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        state_d      = state_q;
        idx_d        = idx_q;
        taken_d      = taken_q;
        hist_d       = hist_q;
        count_d      = count_q;
        lht_w_v_d    = 1'b0;
        lht_w_addr_d = '0;
        lht_w_data_d = '0;
        pht_w_v_d    = 1'b0;
        pht_w_addr_d = '0;
        pht_w_data_d = '0;

        if (push) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = {resolve_pc_i[PC_IDX_W+1:2], resolve_taken_i};
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
                    idx_d    = head[PC_IDX_W:1];
                    taken_d  = head[0];
                    state_d  = S_RD_LHT;
                end
            end
            S_RD_LHT: begin
                hist_d  = lht_r_data_i;
                state_d = S_RD_PHT;
            end
            S_RD_PHT: begin
                // Write-side values are registered here so the WRITE-cycle strobes come from flops.
                lht_w_v_d    = 1'b1;
                lht_w_addr_d = idx_q;
                lht_w_data_d = {hist_q[HIST_W-2:0], taken_q};
                pht_w_v_d    = 1'b1;
                pht_w_addr_d = hist_q;
                if (taken_q) pht_w_data_d = (pht_r_data_i == 2'd3) ? 2'd3 : pht_r_data_i + 2'd1;
                else         pht_w_data_d = (pht_r_data_i == 2'd0) ? 2'd0 : pht_r_data_i - 2'd1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                count_d = count_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= S_IDLE;
            idx_q        <= '0;
            taken_q      <= 1'b0;
            hist_q       <= '0;
            count_q      <= '0;
            lht_w_v_q    <= 1'b0;
            lht_w_addr_q <= '0;
            lht_w_data_q <= '0;
            pht_w_v_q    <= 1'b0;
            pht_w_addr_q <= '0;
            pht_w_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            taken_q      <= taken_d;
            hist_q       <= hist_d;
            count_q      <= count_d;
            lht_w_v_q    <= lht_w_v_d;
            lht_w_addr_q <= lht_w_addr_d;
            lht_w_data_q <= lht_w_data_d;
            pht_w_v_q    <= pht_w_v_d;
            pht_w_addr_q <= pht_w_addr_d;
            pht_w_data_q <= pht_w_data_d;
        end
        fifo_q <= fifo_d;
    end

    // Read strobes depend on same-cycle table data, so they stay combinational.
    assign lht_r_v_o       = pop;
    assign lht_r_addr_o    = pop ? head[PC_IDX_W:1] : '0;
    assign pht_r_v_o       = (state_q == S_RD_LHT);
    assign pht_r_addr_o    = (state_q == S_RD_LHT) ? lht_r_data_i : '0;
    assign lht_w_v_o       = lht_w_v_q;
    assign lht_w_addr_o    = lht_w_addr_q;
    assign lht_w_data_o    = lht_w_data_q;
    assign pht_w_v_o       = pht_w_v_q;
    assign pht_w_addr_o    = pht_w_addr_q;
    assign pht_w_data_o    = pht_w_data_q;
    assign resolve_ready_o = !full;
    assign busy_o          = !empty || (state_q != S_IDLE);
    assign update_count_o  = count_q;

endmodule

// File: tb/tb_bp_two_level_bht_updater.sv
// Bench for bp_two_level_bht_updater: behavioural LHT/PHT memories plus a
// queue-based reference model of the training updates.
module tb_bp_two_level_bht_updater;

    logic        clk = 1'b0;
    logic        reset_i, resolve_v_i, resolve_ready_o, resolve_taken_i;
    logic [31:0] resolve_pc_i;
    logic        lht_r_v_o, lht_w_v_o, pht_r_v_o, pht_w_v_o, busy_o;
    logic [3:0]  lht_r_addr_o, lht_r_data_i, lht_w_addr_o, lht_w_data_o;
    logic [3:0]  pht_r_addr_o, pht_w_addr_o;
    logic [1:0]  pht_r_data_i, pht_w_data_o;
    logic [15:0] update_count_o;

    bp_two_level_bht_updater #(.PC_IDX_W(4), .HIST_W(4), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .resolve_v_i(resolve_v_i), .resolve_ready_o(resolve_ready_o),
        .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
        .lht_r_v_o(lht_r_v_o), .lht_r_addr_o(lht_r_addr_o), .lht_r_data_i(lht_r_data_i),
        .lht_w_v_o(lht_w_v_o), .lht_w_addr_o(lht_w_addr_o), .lht_w_data_o(lht_w_data_o),
        .pht_r_v_o(pht_r_v_o), .pht_r_addr_o(pht_r_addr_o), .pht_r_data_i(pht_r_data_i),
        .pht_w_v_o(pht_w_v_o), .pht_w_addr_o(pht_w_addr_o), .pht_w_data_o(pht_w_data_o),
        .busy_o(busy_o), .update_count_o(update_count_o)
    );

    always #5 clk = ~clk;

    logic [3:0] lht_mem [16];
    logic [1:0] pht_mem [16];

    always @(posedge clk) begin
        if (lht_r_v_o) lht_r_data_i <= lht_mem[lht_r_addr_o];
        if (pht_r_v_o) pht_r_data_i <= pht_mem[pht_r_addr_o];
        if (lht_w_v_o) lht_mem[lht_w_addr_o] <= lht_w_data_o;
        if (pht_w_v_o) pht_mem[pht_w_addr_o] <= pht_w_data_o;
    end

    typedef struct packed { logic [3:0] idx; logic taken; } ent_t;

    ent_t       mq [$];
    logic [3:0] ref_lht [16];
    logic [1:0] ref_pht [16];
    int         exp_count = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lht(input int i, input logic [3:0] v);
        lht_mem[i] = v;
        ref_lht[i] = v;
    endtask

    task automatic set_pht(input int i, input logic [1:0] v);
        pht_mem[i] = v;
        ref_pht[i] = v;
    endtask

    task automatic check_writes();
        ent_t e;
        int h, c, nc, nh;
        chk("rd_strobe_onehot", 32'(lht_r_v_o & pht_r_v_o), 32'd0);
        if (lht_w_v_o || pht_w_v_o) begin
            chk("w_strobe_pair", 32'(lht_w_v_o), 32'(pht_w_v_o));
            if (mq.size() == 0) begin
                chk("unexpected_write", 32'(mq.size()), 32'd1);
            end else begin
                e  = mq.pop_front();
                h  = int'(ref_lht[e.idx]);
                c  = int'(ref_pht[h]);
                if (e.taken) nc = (c == 3) ? 3 : c + 1;
                else         nc = (c == 0) ? 0 : c - 1;
                nh = (h * 2 + int'(e.taken)) % 16;
                chk("lht_w_addr", 32'(lht_w_addr_o), 32'(e.idx));
                chk("lht_w_data", 32'(lht_w_data_o), 32'(nh));
                chk("pht_w_addr", 32'(pht_w_addr_o), 32'(h));
                chk("pht_w_data", 32'(pht_w_data_o), 32'(nc));
                ref_lht[e.idx] = 4'(nh);
                ref_pht[h]     = 2'(nc);
            end
        end
    endtask

    // One clock: record acceptance just before the edge, then check 1 time unit after it.
    task automatic cycle();
        logic acc;
        ent_t e;
        acc = resolve_v_i && resolve_ready_o;
        @(posedge clk);
        if (reset_i) begin
            mq.delete();
            exp_count = 0;
        end else if (acc) begin
            e.idx   = resolve_pc_i[5:2];
            e.taken = resolve_taken_i;
            mq.push_back(e);
            exp_count++;
        end
        #1;
        check_writes();
    endtask

    task automatic push1(input logic [31:0] pc, input logic taken);
        resolve_v_i     = 1'b1;
        resolve_pc_i    = pc;
        resolve_taken_i = taken;
        cycle();
        resolve_v_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (!busy_o) break;
            cycle();
        end
        chk("drain_busy", 32'(busy_o), 32'd0);
        chk("drain_queue", 32'(mq.size()), 32'd0);
        chk("update_count", 32'(update_count_o), 32'(exp_count % 65536));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int sat_ctr [3] = '{3, 0, 2};
        int sat_tk  [3] = '{1, 0, 0};
        int sat_exp [3] = '{3, 0, 1};
        int accepted;
        logic saw_not_ready;

        reset_i = 1'b1; resolve_v_i = 1'b0; resolve_pc_i = '0; resolve_taken_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_lht(i, 4'($urandom));
            set_pht(i, 2'($urandom));
        end
        cycle();
        cycle();
        reset_i = 1'b0;
        chk("rst_ready", 32'(resolve_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_count", 32'(update_count_o), 32'd0);
        chk("rst_strobes", 32'({lht_r_v_o, lht_w_v_o, pht_r_v_o, pht_w_v_o}), 32'd0);
        chk("rst_addr_data", 32'({lht_r_addr_o, lht_w_addr_o, lht_w_data_o,
                                  pht_r_addr_o, pht_w_addr_o, pht_w_data_o}), 32'd0);

        // Single update with cycle-exact strobe timing.
        set_lht(2, 4'b0101);
        set_pht(5, 2'b01);
        push1(32'h0000_0008, 1'b1);
        chk("t1_lht_r_v", 32'(lht_r_v_o), 32'd1);
        chk("t1_lht_r_addr", 32'(lht_r_addr_o), 32'd2);
        cycle();
        chk("t1_pht_r_v", 32'(pht_r_v_o), 32'd1);
        chk("t1_pht_r_addr", 32'(pht_r_addr_o), 32'd5);
        cycle();
        chk("t1_quiet", 32'({lht_r_v_o, pht_r_v_o, lht_w_v_o, pht_w_v_o}), 32'd0);
        cycle();
        chk("t1_w_v", 32'({lht_w_v_o, pht_w_v_o}), 32'b11);
        chk("t1_pht_w", 32'({pht_w_addr_o, pht_w_data_o}), 32'({4'd5, 2'b10}));
        chk("t1_lht_w", 32'({lht_w_addr_o, lht_w_data_o}), 32'({4'd2, 4'b1011}));
        cycle();
        chk("t1_count", 32'(update_count_o), 32'd1);
        chk("t1_busy", 32'(busy_o), 32'd0);

        // Saturation cases.
        for (int k = 0; k < 3; k++) begin
            set_lht(1, 4'd7);
            set_pht(7, 2'(sat_ctr[k]));
            push1(32'h0000_0004, 1'(sat_tk[k]));
            drain();
            chk("sat_pht", 32'(pht_mem[7]), 32'(sat_exp[k]));
        end

        // Back-to-back updates to the same PC.
        set_lht(2, 4'd0);
        for (int i = 0; i < 16; i++) set_pht(i, 2'd0);
        push1(32'h0000_0008, 1'b1);
        push1(32'h0000_0008, 1'b1);
        drain();
        chk("b2b_lht2", 32'(lht_mem[2]), 32'b0011);
        chk("b2b_pht0", 32'(pht_mem[0]), 32'b01);
        chk("b2b_pht1", 32'(pht_mem[1]), 32'b01);

        // Hold valid for 8 cycles: entries accepted on cycles 1-5 and 7.
        accepted = 0;
        saw_not_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            resolve_v_i     = 1'b1;
            resolve_pc_i    = 32'h100 + 32'(i) * 4;
            resolve_taken_i = 1'(i % 2);
            if (resolve_ready_o) accepted++;
            else saw_not_ready = 1'b1;
            cycle();
        end
        resolve_v_i = 1'b0;
        chk("full_accepted", 32'(accepted), 32'd6);
        chk("full_saw_not_ready", 32'(saw_not_ready), 32'd1);
        drain();

        // Reset while in RD_PHT with two entries queued.
        for (int i = 0; i < 3; i++) push1(32'h40 + 32'(i) * 4, 1'b1);
        chk("mid_busy", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        chk("mid_no_write", 32'({lht_w_v_o, pht_w_v_o}), 32'd0);
        chk("mid_busy_after", 32'(busy_o), 32'd0);
        chk("mid_ready_after", 32'(resolve_ready_o), 32'd1);
        chk("mid_count_after", 32'(update_count_o), 32'd0);
        for (int i = 0; i < 6; i++) cycle();
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            resolve_v_i     = 1'($urandom_range(0, 1));
            resolve_pc_i    = $urandom;
            resolve_taken_i = 1'($urandom_range(0, 1));
            cycle();
        end
        resolve_v_i = 1'b0;
        drain();
        for (int i = 0; i < 16; i++) begin
            chk("final_lht", 32'(lht_mem[i]), 32'(ref_lht[i]));
            chk("final_pht", 32'(pht_mem[i]), 32'(ref_pht[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
